// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared widths, lane index type and FSM state for the stream serializer
package fifo_stream_pkg;

    localparam int IN_W   = 256;
    localparam int OUT_W  = 64;
    localparam int LANES  = 4;
    localparam int LANE_W = $clog2(LANES);

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

endpackage

// File: rtl/sync_fifo_eop.sv
// rtl/sync_fifo_eop.sv - circular word buffer with a per-entry end-of-packet tag bit
module sync_fifo_eop
    import fifo_stream_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [IN_W-1:0]          wr_data,
    input  logic                     wr_eop,
    input  logic                     tag_last,
    input  logic                     pop,
    output logic [IN_W-1:0]          rd_data,
    output logic                     rd_eop,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [IN_W-1:0]  mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(wr_en) - LW'(pop);
        tag_d    = tag_q;
        // Late tag lands on the newest entry, which sits just behind the write pointer
        if (tag_last) begin
            tag_d[wr_ptr_q - AW'(1)] = 1'b1;
        end
        if (wr_en) begin
            tag_d[wr_ptr_q] = wr_eop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            tag_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            tag_q    <= tag_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign rd_eop  = tag_q[rd_ptr_q];
    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign level   = level_q;

endmodule

// File: rtl/fifo_stream_serializer.sv
// rtl/fifo_stream_serializer.sv - buffers 256-bit words and emits them as four 64-bit lanes; SERIALIZER_PKT_CNT_EN enables pkt_cnt
module fifo_stream_serializer
    import fifo_stream_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [IN_W-1:0]          fifo_stream_fifo_data,
    input  logic                     fifo_stream_fifo_write,
    input  logic                     fifo_stream_fifo_send,
    output logic [OUT_W-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_eop,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     orphan_send,
    input  logic                     flag_clr,
    output logic [15:0]              pkt_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    lane_t           lane_q, lane_d;
    logic            overflow_q, overflow_d;
    logic            orphan_q, orphan_d;

    logic [IN_W-1:0] head_data;
    logic            head_eop;
    logic            fifo_empty;
    logic            fifo_full;
    logic            handshake;
    logic            pop;
    logic            wr_accept;
    logic            tag_alone;
    logic            overflow_set;
    logic            orphan_set;

    sync_fifo_eop #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .wr_en    (wr_accept),
        .wr_data  (fifo_stream_fifo_data),
        .wr_eop   (fifo_stream_fifo_send),
        .tag_last (tag_alone),
        .pop      (pop),
        .rd_data  (head_data),
        .rd_eop   (head_eop),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .level    (level)
    );

    always_comb begin
        handshake = out_valid && out_ready;
        pop       = handshake && (lane_q == LAST_LANE);
        wr_accept = fifo_stream_fifo_write && (!fifo_full || pop);
        // A word leaving on this very edge can no longer carry the tag
        tag_alone = fifo_stream_fifo_send && !fifo_stream_fifo_write && !fifo_empty
                    && !(pop && (level == LW'(1)));
        overflow_set = fifo_stream_fifo_write && !wr_accept;
        orphan_set   = fifo_stream_fifo_send
                       && (fifo_stream_fifo_write ? !wr_accept : !tag_alone);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = SHIFT;
                    lane_d  = '0;
                end
            end
            SHIFT: begin
                if (handshake) begin
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        if (!((level > LW'(1)) || wr_accept)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        lane_d = lane_q + lane_t'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lane_d  = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_eop   = 1'b0;
        if (state_q == SHIFT) begin
            out_valid = 1'b1;
            out_data  = head_data[lane_q*OUT_W +: OUT_W];
            out_eop   = (lane_q == LAST_LANE) && head_eop;
        end
    end

    // Set wins over a clear arriving in the same cycle
    always_comb begin
        overflow_d = overflow_set ? 1'b1 : (flag_clr ? 1'b0 : overflow_q);
        orphan_d   = orphan_set   ? 1'b1 : (flag_clr ? 1'b0 : orphan_q);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            overflow_q <= 1'b0;
            orphan_q   <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            orphan_q   <= orphan_d;
        end
    end

    assign overflow    = overflow_q;
    assign orphan_send = orphan_q;

`ifdef SERIALIZER_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q + 16'(handshake && out_eop);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_serializer.sv
// tb/tb_fifo_stream_serializer.sv - randomized and directed self-checking bench against a queue model
module tb_fifo_stream_serializer;

    localparam int DEPTH = 8;

    logic           clk;
    logic           rst_n;
    logic [255:0]   d;
    logic           w;
    logic           s;
    logic [63:0]    out_data;
    logic           out_valid;
    logic           r;
    logic           out_eop;
    logic [3:0]     level;
    logic           overflow;
    logic           orphan_send;
    logic           clr;
    logic [15:0]    pkt_cnt;

    int checks = 0;
    int errors = 0;

    fifo_stream_serializer #(.DEPTH(DEPTH)) dut (
        .clk_clk                (clk),
        .reset_reset_n          (rst_n),
        .fifo_stream_fifo_data  (d),
        .fifo_stream_fifo_write (w),
        .fifo_stream_fifo_send  (s),
        .out_data               (out_data),
        .out_valid              (out_valid),
        .out_ready              (r),
        .out_eop                (out_eop),
        .level                  (level),
        .overflow               (overflow),
        .orphan_send            (orphan_send),
        .flag_clr               (clr),
        .pkt_cnt                (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of buffered words/tags, whether a word is being presented, and its lane
    logic [255:0] mq[$];
    bit           mt[$];
    bit           mv;
    int           ml;
    bit           movf;
    bit           morph;
    logic [15:0]  mpkt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mt.delete();
            mv = 0; ml = 0; movf = 0; morph = 0; mpkt = '0;
        end else begin
            int  sz;
            bit  fire, popw, eop_now, acc, tag_ok, oset, rset, was_v;
            sz      = mq.size();
            was_v   = mv;
            fire    = mv && r;
            popw    = fire && (ml == 3);
            eop_now = mv && (ml == 3) && mt[0];
            acc     = w && ((sz < DEPTH) || popw);
            tag_ok  = s && !w && (sz > 0) && !(popw && sz == 1);
            oset    = w && !acc;
            rset    = s && (w ? !acc : !tag_ok);
            if (fire && eop_now) mpkt = mpkt + 16'd1;
            if (tag_ok) mt[sz-1] = 1'b1;
            movf  = oset ? 1'b1 : (clr ? 1'b0 : movf);
            morph = rset ? 1'b1 : (clr ? 1'b0 : morph);
            if (popw) begin
                void'(mq.pop_front());
                void'(mt.pop_front());
            end
            if (acc) begin
                mq.push_back(d);
                mt.push_back(s);
            end
            if (!was_v) begin
                if (sz > 0) begin
                    mv = 1; ml = 0;
                end
            end else if (fire) begin
                if (ml == 3) begin
                    ml = 0;
                    mv = (mq.size() > 0);
                end else begin
                    ml = ml + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [255:0] hw;
            logic [15:0]  ep;
`ifdef SERIALIZER_PKT_CNT_EN
            ep = mpkt;
`else
            ep = 16'd0;
`endif
            chk("out_valid", 64'(out_valid), 64'(mv));
            if (mv) begin
                hw = mq[0];
                chk("out_data", out_data, hw[ml*64 +: 64]);
                chk("out_eop", 64'(out_eop), 64'((ml == 3) && mt[0]));
            end
            chk("level", 64'(level), 64'(mq.size()));
            chk("overflow", 64'(overflow), 64'(movf));
            chk("orphan_send", 64'(orphan_send), 64'(morph));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(ep));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        if (!out_valid) begin
            errors++;
            checks++;
            $display("FAIL %s timeout actual=0 required=1", name);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        r = 1;
        while ((level != 0 || out_valid) && k < 400) begin
            tick();
            k++;
        end
        chk(name, 64'(level != 0 || out_valid), 64'd0);
    endtask

    function automatic logic [255:0] pat(input logic [63:0] base);
        logic [255:0] p;
        for (int k = 0; k < 4; k++) p[k*64 +: 64] = base * 64'(k + 1);
        return p;
    endfunction

    initial begin
        logic [255:0] p;
        int           cnt;
        bit           saw_eop;

        rst_n = 0; w = 0; s = 0; r = 0; clr = 0; d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_eop", 64'(out_eop), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);
        #1 rst_n = 1;
        tick();

        // Single packet, free-running consumer
        p = pat(64'h0101010101010101);
        r = 1; w = 1; s = 1; d = p;
        tick();
        w = 0; s = 0;
        wait_valid("single_valid");
        chk("single_lane0", out_data, 64'h0101010101010101);
        chk("single_eop0", 64'(out_eop), 64'd0);
        tick();
        chk("single_lane1", out_data, 64'h0202020202020202);
        chk("single_eop1", 64'(out_eop), 64'd0);
        tick();
        chk("single_lane2", out_data, 64'h0303030303030303);
        chk("single_eop2", 64'(out_eop), 64'd0);
        tick();
        chk("single_lane3", out_data, 64'h0404040404040404);
        chk("single_eop3", 64'(out_eop), 64'd1);
        tick();
        chk("single_done", 64'(out_valid), 64'd0);
`ifdef SERIALIZER_PKT_CNT_EN
        chk("single_pkt", 64'(pkt_cnt), 64'd1);
`else
        chk("single_pkt", 64'(pkt_cnt), 64'd0);
`endif

        // Backpressure during lane 1
        r = 0; w = 1; s = 1; d = pat(64'h1111111111111111);
        tick();
        w = 0; s = 0;
        wait_valid("bp_valid");
        r = 1;
        tick();
        r = 0;
        chk("bp_stall_a", out_data, 64'h2222222222222222);
        tick();
        chk("bp_stall_b", out_data, 64'h2222222222222222);
        r = 1;
        tick();
        chk("bp_lane2", out_data, 64'h3333333333333333);
        tick();
        chk("bp_lane3", out_data, 64'h4444444444444444);
        chk("bp_eop3", 64'(out_eop), 64'd1);
        tick();

        // Nine writes into a stalled DEPTH=8 buffer
        r = 0;
        for (int i = 1; i <= 9; i++) begin
            w = 1; d = {8{32'(i)}};
            tick();
        end
        w = 0;
        chk("ovf_level", 64'(level), 64'd8);
        chk("ovf_flag", 64'(overflow), 64'd1);
        r = 1;
        cnt = 0;
        for (int k = 0; k < 200 && (level != 0 || out_valid); k++) begin
            if (out_valid) cnt++;
            tick();
        end
        chk("ovf_lanes", 64'(cnt), 64'd32);
        clr = 1;
        tick();
        clr = 0;
        chk("ovf_clear", 64'(overflow), 64'd0);

        // Full buffer: write lands on the final-lane pop
        r = 0;
        for (int i = 0; i < 8; i++) begin
            w = 1; d = {8{$urandom()}};
            tick();
        end
        w = 0;
        chk("full_level", 64'(level), 64'd8);
        r = 1;
        tick(); tick(); tick();
        w = 1; d = {8{32'hCAFE0000}};
        tick();
        w = 0; r = 0;
        chk("full_pop_level", 64'(level), 64'd8);
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        drain("full_drain");

        // Late send tags a buffered word, then a send with nothing buffered
        r = 0; w = 1; d = {8{32'h5A5A0001}};
        tick();
        w = 0; s = 1;
        tick();
        s = 0; r = 1;
        saw_eop = 0;
        for (int k = 0; k < 20 && (level != 0 || out_valid); k++) begin
            if (out_valid && out_eop) saw_eop = 1;
            tick();
        end
        chk("late_send_eop", 64'(saw_eop), 64'd1);
        chk("orphan_before", 64'(orphan_send), 64'd0);
        s = 1;
        tick();
        s = 0;
        chk("orphan_set", 64'(orphan_send), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("orphan_no_out", 64'(out_valid), 64'd0);
        end
        clr = 1;
        tick();
        clr = 0;

        // Reset in the middle of a burst
        r = 0;
        for (int i = 0; i < 3; i++) begin
            w = 1; d = pat(64'h0000000100000000 + 64'(i));
            tick();
        end
        w = 0;
        wait_valid("mid_valid");
        r = 1;
        tick(); tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_eop", 64'(out_eop), 64'd0);
        chk("mid_rst_level", 64'(level), 64'd0);
        @(negedge clk);
        #1 rst_n = 1;
        tick();
        p = pat(64'h0A0A0A0A0A0A0A0A);
        w = 1; d = p;
        tick();
        w = 0;
        wait_valid("post_rst_valid");
        chk("post_rst_lane0", out_data, 64'h0A0A0A0A0A0A0A0A);
        drain("post_rst_drain");

        // Random traffic checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            w   = ($urandom % 2) == 0;
            s   = ($urandom % 5) == 0;
            r   = ($urandom % 3) != 0;
            clr = ($urandom % 20) == 0;
            d   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        w = 0; s = 0; clr = 0;
        drain("rand_drain");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
